// File: rtl/rf_bank_arbiter_pkg.sv
// Shared constants, request payload type and bank-match helper for the RF bank arbiter.
package rf_bank_arbiter_pkg;

   localparam int unsigned NUM_BANKS  = 4;
   localparam int unsigned BANK_W     = 2;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W      = PTR_W + 1;
   localparam int unsigned ROW_W      = 3;
   localparam int unsigned OCID_W     = 3;
   localparam int unsigned DATA_W     = 256;

   // One queued bank read: physical row plus the collector slot that wants it.
   typedef struct packed {
      logic [ROW_W-1:0]  row;
      logic [OCID_W-1:0] ocid;
   } rf_req_t;

   // True when a valid operand/write targets bank b.
   function automatic logic bank_hit(input logic vld, input logic [BANK_W-1:0] bank,
                                     input int unsigned b);
      return vld && (bank == BANK_W'(b));
   endfunction

endpackage

// File: rtl/rf_bank_arbiter_if.sv
// Bundle of request, writeback, bank and operand-collector signals around the arbiter.
interface rf_bank_arbiter_if;
   import rf_bank_arbiter_pkg::*;

   logic                          req_valid;
   logic                          src1_valid;
   logic [BANK_W-1:0]             src1_bank;
   logic [ROW_W-1:0]              src1_row;
   logic [OCID_W-1:0]             src1_ocid;
   logic                          src2_valid;
   logic [BANK_W-1:0]             src2_bank;
   logic [ROW_W-1:0]              src2_row;
   logic [OCID_W-1:0]             src2_ocid;
   logic                          stall_out;
   logic                          wr_valid;
   logic [BANK_W-1:0]             wr_bank;
   logic [ROW_W-1:0]              wr_row;
   logic [DATA_W-1:0]             wr_data;
   logic [NUM_BANKS-1:0]          bank_rd_en;
   logic [NUM_BANKS*ROW_W-1:0]    bank_rd_row;
   logic [NUM_BANKS*DATA_W-1:0]   bank_rd_data;
   logic [NUM_BANKS-1:0]          bank_wr_en;
   logic [ROW_W-1:0]              bank_wr_row;
   logic [DATA_W-1:0]             bank_wr_data;
   logic [NUM_BANKS-1:0]          oc_valid;
   logic [NUM_BANKS*OCID_W-1:0]   oc_ocid;
   logic [NUM_BANKS*DATA_W-1:0]   oc_data;

   // Arbiter side.
   modport slave (
      input  req_valid, src1_valid, src1_bank, src1_row, src1_ocid,
             src2_valid, src2_bank, src2_row, src2_ocid,
             wr_valid, wr_bank, wr_row, wr_data, bank_rd_data,
      output stall_out, bank_rd_en, bank_rd_row, bank_wr_en, bank_wr_row, bank_wr_data,
             oc_valid, oc_ocid, oc_data
   );

   // Mapping unit / CDB / bank / collector side.
   modport master (
      output req_valid, src1_valid, src1_bank, src1_row, src1_ocid,
             src2_valid, src2_bank, src2_row, src2_ocid,
             wr_valid, wr_bank, wr_row, wr_data, bank_rd_data,
      input  stall_out, bank_rd_en, bank_rd_row, bank_wr_en, bank_wr_row, bank_wr_data,
             oc_valid, oc_ocid, oc_data
   );

endinterface

// File: rtl/rf_bank_arbiter_bank_req_fifo.sv
// Per-bank request FIFO: up to two pushes (a before b) and one pop per cycle.
module rf_bank_arbiter_bank_req_fifo
   import rf_bank_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push_a_i,
   input  rf_req_t          data_a_i,
   input  logic             push_b_i,
   input  rf_req_t          data_b_i,
   input  logic             pop_i,
   output rf_req_t          head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   rf_req_t          mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] slot_b_c;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointer/count update; b lands after a so the older operand pops first.
   always_comb begin
      slot_b_c = wr_ptr_q + PTR_W'(push_a_i);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_a_i) + PTR_W'(push_b_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      count_d  = count_q + CNT_W'(push_a_i) + CNT_W'(push_b_i) - CNT_W'(pop_i);
   end

   // Control state, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care while the slot is not occupied.
   always_ff @(posedge clk) begin
      if (push_a_i) mem_q[wr_ptr_q] <= data_a_i;
      if (push_b_i) mem_q[slot_b_c] <= data_b_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
                                    count_q <= CNT_W'(FIFO_DEPTH));
   a_no_empty_pop : assert property (@(posedge clk) disable iff (!rst)
                                     pop_i |-> !empty_o);

endmodule

// File: rtl/rf_bank_arbiter.sv
// Register-file bank arbiter: queues operand reads per bank, gives CDB writes priority,
// and returns read data tagged with the collector slot one cycle after the bank read.
module rf_bank_arbiter
   import rf_bank_arbiter_pkg::*;
(
   input logic              clk,
   input logic              rst,
   rf_bank_arbiter_if.slave bus
);

   localparam int unsigned NEED_W = CNT_W + 1;

   logic [NUM_BANKS-1:0]              src1_hit_c, src2_hit_c, over_c;
   logic [NUM_BANKS-1:0]              push_a_c, push_b_c;
   logic [NUM_BANKS-1:0]              wr_hit_c, rd_en_c, empty_c;
   logic [NUM_BANKS*ROW_W-1:0]        rd_row_c;
   logic [CNT_W-1:0]                  count_c [NUM_BANKS];
   rf_req_t                           head_c  [NUM_BANKS];
   rf_req_t                           req1_c, req2_c;
   logic                              stall_c, accept_c;
   logic [NUM_BANKS-1:0]              oc_valid_q;
   logic [NUM_BANKS-1:0][OCID_W-1:0]  oc_ocid_q, oc_ocid_d;

   // Per-bank demand, stall on any bank that cannot take its operands, atomic accept.
   always_comb begin
      src1_hit_c = '0;
      src2_hit_c = '0;
      over_c     = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         src1_hit_c[b] = bank_hit(bus.src1_valid, bus.src1_bank, b);
         src2_hit_c[b] = bank_hit(bus.src2_valid, bus.src2_bank, b);
         over_c[b]     = (NEED_W'(count_c[b]) + NEED_W'(src1_hit_c[b]) + NEED_W'(src2_hit_c[b]))
                         > NEED_W'(FIFO_DEPTH);
      end
      stall_c  = bus.req_valid && (|over_c);
      accept_c = bus.req_valid && !stall_c;
      push_a_c = src1_hit_c & {NUM_BANKS{accept_c}};
      push_b_c = src2_hit_c & {NUM_BANKS{accept_c}};
      req1_c   = '{row: bus.src1_row, ocid: bus.src1_ocid};
      req2_c   = '{row: bus.src2_row, ocid: bus.src2_ocid};
   end

   // One request FIFO per bank.
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      rf_bank_arbiter_bank_req_fifo u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push_a_i (push_a_c[g]),
         .data_a_i (req1_c),
         .push_b_i (push_b_c[g]),
         .data_b_i (req2_c),
         .pop_i    (rd_en_c[g]),
         .head_o   (head_c[g]),
         .count_o  (count_c[g]),
         .empty_o  (empty_c[g])
      );
   end

   // Issue: a writeback owns its bank this cycle, otherwise pop and read the head.
   always_comb begin
      wr_hit_c  = '0;
      rd_en_c   = '0;
      rd_row_c  = '0;
      oc_ocid_d = oc_ocid_q;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         wr_hit_c[b] = bank_hit(bus.wr_valid, bus.wr_bank, b);
         rd_en_c[b]  = rst && !wr_hit_c[b] && !empty_c[b];
         rd_row_c[b*ROW_W +: ROW_W] = head_c[b].row;
         if (rd_en_c[b]) oc_ocid_d[b] = head_c[b].ocid;
      end
   end

   // Return pipeline: tag lines up with bank data arriving the cycle after the read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         oc_valid_q <= '0;
         oc_ocid_q  <= '0;
      end else begin
         oc_valid_q <= rd_en_c;
         oc_ocid_q  <= oc_ocid_d;
      end
   end

   assign bus.stall_out    = stall_c;
   assign bus.bank_rd_en   = rd_en_c;
   assign bus.bank_rd_row  = rd_row_c;
   assign bus.bank_wr_en   = wr_hit_c;
   assign bus.bank_wr_row  = bus.wr_row;
   assign bus.bank_wr_data = bus.wr_data;
   assign bus.oc_valid     = oc_valid_q;
   assign bus.oc_ocid      = oc_ocid_q;
   assign bus.oc_data      = bus.bank_rd_data;

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Bench for rf_bank_arbiter: directed vector table, reset sequence, then random traffic
// checked against a queue-based model with behavioural register-file banks.
module tb_rf_bank_arbiter;
   import rf_bank_arbiter_pkg::*;

   typedef struct { int row; int ocid; } ent_t;
   typedef struct {
      logic rst; logic req;
      logic s1v; int s1b; int s1r; int s1o;
      logic s2v; int s2b; int s2r; int s2o;
      logic wv;  int wb;  int wr;
      logic xstall; logic [3:0] xrd; logic [3:0] xwr; logic [3:0] xocv;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rf_bank_arbiter_if bus ();
   rf_bank_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   ent_t              q [NUM_BANKS][$];
   logic [DATA_W-1:0] mem_m    [NUM_BANKS][8];
   logic [DATA_W-1:0] bank_mem [NUM_BANKS][8];
   logic [NUM_BANKS-1:0] exp_ocv = '0;
   int                exp_ocid [NUM_BANKS];
   logic [DATA_W-1:0] exp_data [NUM_BANKS];
   logic              last_stall = 1'b0;
   logic              tv_on = 1'b0;
   int                tv_idx = 0;
   vec_t              cur;
   vec_t              tv [$];

   function automatic logic [DATA_W-1:0] rnd256();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic vec_t mk(logic req, logic s1v, int s1b, int s1r, int s1o,
                               logic s2v, int s2b, int s2r, int s2o,
                               logic wv, int wb, int wr,
                               logic xs, logic [3:0] xrd, logic [3:0] xwr, logic [3:0] xocv);
      vec_t v;
      v.rst = 1'b1; v.req = req;
      v.s1v = s1v; v.s1b = s1b; v.s1r = s1r; v.s1o = s1o;
      v.s2v = s2v; v.s2b = s2b; v.s2r = s2r; v.s2o = s2o;
      v.wv = wv; v.wb = wb; v.wr = wr;
      v.xstall = xs; v.xrd = xrd; v.xwr = xwr; v.xocv = xocv;
      return v;
   endfunction

   function automatic vec_t idle(logic [3:0] xrd, logic [3:0] xocv);
      return mk(0, 0,0,0,0, 0,0,0,0, 0,0,0, 0, xrd, 4'b0000, xocv);
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic set_in(input vec_t v);
      rst            = v.rst;
      bus.req_valid  = v.req;
      bus.src1_valid = v.s1v; bus.src1_bank = 2'(v.s1b); bus.src1_row = 3'(v.s1r); bus.src1_ocid = 3'(v.s1o);
      bus.src2_valid = v.s2v; bus.src2_bank = 2'(v.s2b); bus.src2_row = 3'(v.s2r); bus.src2_ocid = 3'(v.s2o);
      bus.wr_valid   = v.wv;  bus.wr_bank   = 2'(v.wb);  bus.wr_row   = 3'(v.wr);
      bus.wr_data    = rnd256();
   endtask

   // One clock: check outputs against model (and table row if active), then advance model and banks.
   task automatic tick();
      int need;
      logic e_stall, acc;
      logic [NUM_BANKS-1:0] e_wr, e_rd, s_rd, s_wr;
      logic [NUM_BANKS*ROW_W-1:0] s_row;
      logic [ROW_W-1:0]  s_wrow;
      logic [DATA_W-1:0] s_wdata;
      logic [DATA_W-1:0] lat [NUM_BANKS];
      ent_t e;
      #3;
      e_stall = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         need = int'(bus.src1_valid && bus.src1_bank == 2'(b)) + int'(bus.src2_valid && bus.src2_bank == 2'(b));
         if (q[b].size() + need > FIFO_DEPTH) e_stall = 1'b1;
         e_wr[b] = bus.wr_valid && bus.wr_bank == 2'(b);
         e_rd[b] = rst && !e_wr[b] && q[b].size() != 0;
      end
      e_stall = e_stall && bus.req_valid;
      acc = bus.req_valid && !e_stall;

      chk("stall_out", DATA_W'(bus.stall_out), DATA_W'(e_stall));
      chk("bank_rd_en", DATA_W'(bus.bank_rd_en), DATA_W'(e_rd));
      chk("bank_wr_en", DATA_W'(bus.bank_wr_en), DATA_W'(e_wr));
      if (bus.wr_valid) begin
         chk("bank_wr_row", DATA_W'(bus.bank_wr_row), DATA_W'(bus.wr_row));
         chk("bank_wr_data", bus.bank_wr_data, bus.wr_data);
      end
      chk("oc_valid", DATA_W'(bus.oc_valid), DATA_W'(exp_ocv));
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (e_rd[b])
            chk($sformatf("bank_rd_row[%0d]", b), DATA_W'(bus.bank_rd_row[b*ROW_W +: ROW_W]), DATA_W'(q[b][0].row));
         if (exp_ocv[b]) begin
            chk($sformatf("oc_ocid[%0d]", b), DATA_W'(bus.oc_ocid[b*OCID_W +: OCID_W]), DATA_W'(exp_ocid[b]));
            chk($sformatf("oc_data[%0d]", b), bus.oc_data[b*DATA_W +: DATA_W], exp_data[b]);
         end
      end
      if (tv_on) begin
         chk($sformatf("tv%0d_stall", tv_idx), DATA_W'(bus.stall_out), DATA_W'(cur.xstall));
         chk($sformatf("tv%0d_rd_en", tv_idx), DATA_W'(bus.bank_rd_en), DATA_W'(cur.xrd));
         chk($sformatf("tv%0d_wr_en", tv_idx), DATA_W'(bus.bank_wr_en), DATA_W'(cur.xwr));
         chk($sformatf("tv%0d_oc_valid", tv_idx), DATA_W'(bus.oc_valid), DATA_W'(cur.xocv));
      end
      s_rd = bus.bank_rd_en; s_row = bus.bank_rd_row; s_wr = bus.bank_wr_en;
      s_wrow = bus.bank_wr_row; s_wdata = bus.bank_wr_data;

      @(posedge clk);
      #1;
      if (!rst) begin
         for (int b = 0; b < NUM_BANKS; b++) q[b].delete();
         exp_ocv = '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            exp_ocv[b] = e_rd[b];
            if (e_rd[b]) begin
               exp_ocid[b] = q[b][0].ocid;
               exp_data[b] = mem_m[b][q[b][0].row];
               void'(q[b].pop_front());
            end
         end
         if (acc && bus.src1_valid) begin
            e.row = int'(bus.src1_row); e.ocid = int'(bus.src1_ocid);
            q[int'(bus.src1_bank)].push_back(e);
         end
         if (acc && bus.src2_valid) begin
            e.row = int'(bus.src2_row); e.ocid = int'(bus.src2_ocid);
            q[int'(bus.src2_bank)].push_back(e);
         end
      end
      if (bus.wr_valid) mem_m[int'(bus.wr_bank)][int'(bus.wr_row)] = bus.wr_data;
      // Banks respond to the strobes the DUT actually produced.
      for (int b = 0; b < NUM_BANKS; b++)
         lat[b] = s_rd[b] ? bank_mem[b][int'(s_row[b*ROW_W +: ROW_W])] : rnd256();
      for (int b = 0; b < NUM_BANKS; b++)
         if (s_wr[b]) bank_mem[b][int'(s_wrow)] = s_wdata;
      for (int b = 0; b < NUM_BANKS; b++)
         bus.bank_rd_data[b*DATA_W +: DATA_W] = lat[b];
      last_stall = e_stall;
   endtask

   initial begin
      vec_t v;
      for (int b = 0; b < NUM_BANKS; b++)
         for (int r = 0; r < 8; r++) begin
            mem_m[b][r]    = rnd256();
            bank_mem[b][r] = mem_m[b][r];
         end
      for (int b = 0; b < NUM_BANKS; b++) exp_ocid[b] = 0;
      bus.bank_rd_data = '0;
      v = idle(4'b0000, 4'b0000);
      v.rst = 1'b0;
      set_in(v);
      @(posedge clk);
      #1;

      // Reset state: two cycles held in reset, then idle.
      tv_on = 1'b1;
      cur = v;
      tick(); tick();

      // Directed vectors: single read, same-bank conflict, write priority, empty request, fill/stall.
      tv.push_back(mk(1, 1,1,5,2, 0,0,0,0, 0,0,0, 0, 4'b0000, 4'b0000, 4'b0000));
      tv.push_back(idle(4'b0010, 4'b0000));
      tv.push_back(idle(4'b0000, 4'b0010));
      tv.push_back(mk(1, 1,2,1,4, 1,2,3,5, 0,0,0, 0, 4'b0000, 4'b0000, 4'b0000));
      tv.push_back(idle(4'b0100, 4'b0000));
      tv.push_back(idle(4'b0100, 4'b0100));
      tv.push_back(idle(4'b0000, 4'b0100));
      tv.push_back(mk(1, 1,0,2,1, 0,0,0,0, 0,0,0, 0, 4'b0000, 4'b0000, 4'b0000));
      tv.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,0,6, 0, 4'b0000, 4'b0001, 4'b0000));
      tv.push_back(idle(4'b0001, 4'b0000));
      tv.push_back(idle(4'b0000, 4'b0001));
      tv.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0, 0, 4'b0000, 4'b0000, 4'b0000));
      tv.push_back(mk(1, 1,3,0,0, 1,3,1,1, 1,3,7, 0, 4'b0000, 4'b1000, 4'b0000));
      tv.push_back(mk(1, 1,3,2,2, 1,3,3,3, 1,3,7, 0, 4'b0000, 4'b1000, 4'b0000));
      tv.push_back(mk(1, 1,3,4,4, 1,3,5,5, 1,3,7, 1, 4'b0000, 4'b1000, 4'b0000));
      tv.push_back(mk(1, 1,3,4,4, 1,3,5,5, 1,3,7, 1, 4'b0000, 4'b1000, 4'b0000));
      tv.push_back(mk(1, 1,3,4,4, 1,3,5,5, 0,0,0, 1, 4'b1000, 4'b0000, 4'b0000));
      tv.push_back(mk(1, 1,3,4,4, 1,3,5,5, 0,0,0, 1, 4'b1000, 4'b0000, 4'b1000));
      tv.push_back(mk(1, 1,3,4,4, 1,3,5,5, 0,0,0, 0, 4'b1000, 4'b0000, 4'b1000));
      tv.push_back(idle(4'b1000, 4'b1000));
      tv.push_back(idle(4'b1000, 4'b1000));
      tv.push_back(idle(4'b1000, 4'b1000));
      tv.push_back(idle(4'b0000, 4'b1000));
      tv.push_back(idle(4'b0000, 4'b0000));
      for (int i = 0; i < tv.size(); i++) begin
         tv_idx = i;
         cur = tv[i];
         set_in(cur);
         tick();
      end

      // Reset mid-operation: three reads parked on bank1 behind writes, then one reset cycle.
      tv_idx = 100;
      cur = mk(1, 1,1,1,1, 1,1,2,2, 1,1,3, 0, 4'b0000, 4'b0010, 4'b0000);
      set_in(cur); tick();
      tv_idx = 101;
      cur = mk(1, 1,1,4,3, 0,0,0,0, 1,1,3, 0, 4'b0000, 4'b0010, 4'b0000);
      set_in(cur); tick();
      tv_idx = 102;
      cur = idle(4'b0000, 4'b0000);
      cur.rst = 1'b0;
      set_in(cur); tick();
      for (int i = 0; i < 3; i++) begin
         tv_idx = 103 + i;
         cur = idle(4'b0000, 4'b0000);
         set_in(cur); tick();
      end
      tv_on = 1'b0;

      // Random traffic; a stalled request is held unchanged until accepted.
      for (int i = 0; i < 2000; i++) begin
         if (!last_stall) begin
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.src1_valid = ($urandom_range(0, 3) != 0);
            bus.src1_bank  = 2'($urandom_range(0, 3));
            bus.src1_row   = 3'($urandom_range(0, 7));
            bus.src1_ocid  = 3'($urandom_range(0, 7));
            bus.src2_valid = ($urandom_range(0, 2) != 0);
            bus.src2_bank  = 2'($urandom_range(0, 3));
            bus.src2_row   = 3'($urandom_range(0, 7));
            bus.src2_ocid  = 3'($urandom_range(0, 7));
         end
         bus.wr_valid = ($urandom_range(0, 2) == 0);
         bus.wr_bank  = 2'($urandom_range(0, 3));
         bus.wr_row   = 3'($urandom_range(0, 7));
         bus.wr_data  = rnd256();
         rst          = ($urandom_range(0, 249) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
